// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and the canonical NOP.
// NOP_INSTR_HEX is the bubble encoding the ID/EX register loads on idex_flush.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } hazard_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0013;

    localparam int REG_ADDR_W = 5;

    // Width of a counter that must hold the value n without wrapping.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the ID/EX datapath and the hazard unit.
// The slave side is the hazard unit; the master side is the pipeline.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] rs1_id;
    logic [REG_ADDR_W-1:0] rs2_id;
    logic                  uses_rs1_id;
    logic                  uses_rs2_id;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic                  memRead_ex;
    logic                  branch_taken_ex;
    logic                  ecall_id;
    logic                  mem_busy;

    logic                  pc_stall;
    logic                  ifid_stall;
    logic                  ifid_flush;
    logic                  idex_hold;
    logic                  idex_flush;
    logic                  exmem_stall;
    logic                  halt;
    logic [1:0]            state_dbg;

    modport slave (
        input  rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, rd_ex, memRead_ex,
               branch_taken_ex, ecall_id, mem_busy,
        output pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush,
               exmem_stall, halt, state_dbg
    );

    modport master (
        output rs1_id, rs2_id, uses_rs1_id, uses_rs2_id, rd_ex, memRead_ex,
               branch_taken_ex, ecall_id, mem_busy,
        input  pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush,
               exmem_stall, halt, state_dbg
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_cmp.sv
// Load-use detector: the ID instruction reads the register a load in EX is about to write.
// x0 is never a real dependency since writes to it are discarded.
module hazard_load_use_cmp
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  uses_rs1_i,
    input  logic                  uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] rd_ex_i,
    input  logic                  mem_read_ex_i,
    output logic                  load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = uses_rs1_i && (rs1_i == rd_ex_i);
    assign rs2_hit    = uses_rs2_i && (rs2_i == rd_ex_i);
    assign load_use_o = mem_read_ex_i && (rd_ex_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/control unit for the 5-stage pipe: load-use interlock, branch squash,
// data-memory wait and the ECALL drain-then-halt sequence.
//
// state | meaning
// RUN   | normal issue; branch squash, load-use bubble, ECALL acceptance
// DRAIN | ECALL in flight to WB; fetch frozen, NOPs fed behind it
// HALT  | ECALL retired; core stopped until rst
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam int CNT_W = cnt_width(DRAIN_CYCLES);

    hazard_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    hazard_load_use_cmp u_load_use_cmp (
        .rs1_i         (hz.rs1_id),
        .rs2_i         (hz.rs2_id),
        .uses_rs1_i    (hz.uses_rs1_id),
        .uses_rs2_i    (hz.uses_rs2_id),
        .rd_ex_i       (hz.rd_ex),
        .mem_read_ex_i (hz.memRead_ex),
        .load_use_o    (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hz.pc_stall    = 1'b0;
        hz.ifid_stall  = 1'b0;
        hz.ifid_flush  = 1'b0;
        hz.idex_hold   = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.exmem_stall = 1'b0;

        // A memory wait freezes the whole pipe, including this FSM.
        if (hz.mem_busy) begin
            hz.pc_stall    = 1'b1;
            hz.ifid_stall  = 1'b1;
            hz.idex_hold   = 1'b1;
            hz.exmem_stall = 1'b1;
        end else begin
            unique case (state_q)
                HALT: begin
                    hz.pc_stall   = 1'b1;
                    hz.ifid_flush = 1'b1;
                end
                DRAIN: begin
                    hz.pc_stall   = 1'b1;
                    hz.ifid_flush = 1'b1;
                    // Counter stops at 1 so it can never wrap.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = HALT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (hz.branch_taken_ex) begin
                        hz.ifid_flush = 1'b1;
                        hz.idex_flush = 1'b1;
                    end else if (load_use) begin
                        hz.pc_stall   = 1'b1;
                        hz.ifid_stall = 1'b1;
                        hz.idex_flush = 1'b1;
                    end else if (hz.ecall_id) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(DRAIN_CYCLES);
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign hz.halt      = (state_q == HALT);
    assign hz.state_dbg = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expected outputs.
// Output vector: {pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush, exmem_stall, halt, state[1:0]}.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] O_IDLE   = 9'b000000_0_00;
    localparam logic [8:0] O_LDUSE  = 9'b110010_0_00;
    localparam logic [8:0] O_BRANCH = 9'b001010_0_00;
    localparam logic [8:0] O_DRAIN  = 9'b101000_0_01;
    localparam logic [8:0] O_HALT   = 9'b101000_1_10;
    localparam logic [8:0] O_BUSY_R = 9'b110101_0_00;
    localparam logic [8:0] O_BUSY_D = 9'b110101_0_01;
    localparam logic [8:0] O_BUSY_H = 9'b110101_1_10;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] outs();
        return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_hold,
                hz.idex_flush, hz.exmem_stall, hz.halt, hz.state_dbg};
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mr, input logic br, input logic ec, input logic mb);
        hz.rs1_id          = rs1;
        hz.rs2_id          = rs2;
        hz.uses_rs1_id     = u1;
        hz.uses_rs2_id     = u2;
        hz.rd_ex           = rd;
        hz.memRead_ex      = mr;
        hz.branch_taken_ex = br;
        hz.ecall_id        = ec;
        hz.mem_busy        = mb;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check combinational outputs mid-cycle, then advance to just after the next edge.
    task automatic step(input string tag, input logic [8:0] exp);
        #3;
        check(tag, outs(), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        @(posedge clk);
        do_reset();

        step("reset_idle", O_IDLE);

        // Load-use on rs1, then the load has moved to MEM.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lduse_rs1", O_LDUSE);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lduse_release", O_IDLE);

        set_in(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lduse_rs2", O_LDUSE);
        set_in(5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lduse_unused_rs2", O_IDLE);
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lduse_rd_x0", O_IDLE);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step("no_load_no_stall", O_IDLE);

        // Branch overrides load-use and a younger ECALL.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        step("branch_prio", O_BRANCH);
        idle();
        step("branch_stays_run", O_IDLE);

        // ECALL blocked by load-use, accepted next cycle.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        step("ecall_blocked", O_LDUSE);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        step("ecall_accept", O_IDLE);
        idle();
        step("drain_1", O_DRAIN);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        step("drain_2_ignores", O_DRAIN);
        idle();
        step("drain_3", O_DRAIN);
        for (int i = 0; i < 21; i++) begin
            set_in(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            step("halt_hold", O_HALT);
        end
        idle();
        hz.mem_busy = 1'b1;
        step("busy_in_halt", O_BUSY_H);
        idle();
        step("halt_after_busy", O_HALT);

        // Reset in HALT, then ECALL with a mem_busy cycle during drain.
        rst = 1'b1;
        step("rst_cycle_still_halt", O_HALT);
        rst = 1'b0;
        step("after_rst", O_IDLE);
        hz.ecall_id = 1'b1;
        step("ecall2_accept", O_IDLE);
        idle();
        step("drain2_1", O_DRAIN);
        hz.mem_busy = 1'b1;
        step("drain2_busy", O_BUSY_D);
        idle();
        step("drain2_2", O_DRAIN);
        step("drain2_3", O_DRAIN);
        step("halt2_first", O_HALT);

        // mem_busy beats branch and load-use; branch taken once it drops.
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step("busy_prio", O_BUSY_R);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step("branch_after_busy", O_BRANCH);

        // Reset mid-drain returns to RUN.
        hz.branch_taken_ex = 1'b0;
        hz.memRead_ex      = 1'b0;
        hz.ecall_id        = 1'b1;
        step("ecall3_accept", O_IDLE);
        idle();
        step("drain3_1", O_DRAIN);
        rst = 1'b1;
        step("drain3_rst_cycle", O_DRAIN);
        rst = 1'b0;
        step("rst_mid_drain", O_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and control unit for the 5-stage RISC-V pipe. Produces the hold/flush controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Covers:
- load-use interlock;
- taken-branch squash;
- data-memory wait;
- ECALL drain-and-halt sequence.

Sits beside the decoder in ID and drives the stall/flush inputs of every pipeline register.

## Interface
Parameters:
- DRAIN_CYCLES, 3, cycles between ECALL leaving ID and its WB retirement; legal range ≥1.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_id  in  5  rs1 field of the instruction in ID.
- rs2_id  in  5  rs2 field of the instruction in ID.
- uses_rs1_id  in  1  ID instruction reads rs1.
- uses_rs2_id  in  1  ID instruction reads rs2.
- rd_ex  in  5  destination register of the instruction in EX.
- memRead_ex  in  1  EX instruction is a load.
- branch_taken_ex  in  1  EX resolved a taken branch/jump; the PC is redirected this cycle.
- ecall_id  in  1  ID holds an ECALL.
- mem_busy  in  1  data memory not ready this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_hold  out  1  hold ID/EX (its stall_disable input).
- idex_flush  out  1  load bubble (NOP_INSTR_HEX, controls zero) into ID/EX.
- exmem_stall  out  1  hold EX/MEM.
- halt  out  1  ECALL retired; core stopped; sticky until rst.
- state_dbg  out  2  current FSM state encoding.

## Operation
FSM states (hazard_state_t): RUN=0, DRAIN=1, HALT=2. Outputs are combinational from state and inputs. The priority order below is evaluated per cycle; only the highest-priority matching case applies.

1. **mem_busy=1 (any state)**
   - Asserts pc_stall, ifid_stall, idex_hold, exmem_stall; no flush.
   - State and counter frozen.
   - halt keeps its value.
2. **HALT**
   - pc_stall=1, ifid_flush=1, halt=1.
   - All inputs ignored; exit only via rst.
3. **DRAIN**
   - pc_stall=1, ifid_flush=1 (NOPs follow the ECALL).
   - branch_taken_ex, load-use and ecall_id ignored.
   - Each cycle: if cnt==1, go to HALT; else cnt−1.
4. **RUN, branch_taken_ex=1**
   - ifid_flush=1, idex_flush=1.
   - Overrides load-use and ecall_id; the younger ECALL is squashed, state stays RUN.
5. **RUN, load-use**
   - Condition: memRead_ex & rd_ex≠0 & ((uses_rs1_id & rs1_id==rd_ex) | (uses_rs2_id & rs2_id==rd_ex)).
   - pc_stall=1, ifid_stall=1, idex_flush=1 for exactly that cycle.
   - ecall_id in the same cycle is not accepted; it is re-evaluated next cycle.
6. **RUN, ecall_id=1**
   - No stall this cycle; the ECALL advances into ID/EX.
   - Next state DRAIN, cnt←DRAIN_CYCLES.
7. Otherwise all outputs 0.

Width rule:
- cnt width $clog2(DRAIN_CYCLES+1).
- cnt never decrements below 1 and never wraps.

## Timing
- Reset: state=RUN, cnt=0. With idle inputs every output is 0 and state_dbg=0.
- rst asserted mid-DRAIN or in HALT returns to RUN on the next edge. halt drops in the cycle after the rst edge.
- ECALL accepted in cycle N (ecall_id=1, no higher case):
  - DRAIN in cycles N+1..N+DRAIN_CYCLES;
  - halt=1 from cycle N+1+DRAIN_CYCLES, excluding cycles where mem_busy=1.
- Each mem_busy cycle during DRAIN delays halt by one cycle.
- Load-use bubble: 1 cycle. Branch squash: 2 instructions, same cycle as branch_taken_ex.
- The dependent instruction re-evaluates in the next cycle against the new EX contents. A load now in MEM does not re-trigger.

## Structure
- common_def gains hazard_state_t (2-bit enum: RUN, DRAIN, HALT). NOP_INSTR_HEX is reused from the same package.
- One sub-module, hazard_load_use_cmp: combinational; rs1/rs2/uses/rd_ex/memRead_ex → load_use flag.
- FSM and counter live in pipeline_hazard_ctrl.

## Test plan
- Load-use: lw x5 in EX (memRead_ex=1, rd_ex=5); ID add with rs1=5, uses_rs1=1 → one cycle of pc_stall=ifid_stall=idex_flush=1, then all 0. Same stimulus with rd_ex=0 → no stall.
- Branch squash: branch_taken_ex=1 while ecall_id=1 and load-use true → ifid_flush=idex_flush=1, no stall, state stays RUN, halt never rises.
- ECALL drain (DRAIN_CYCLES=3): ecall_id=1 at cycle 10 → state_dbg=1 in cycles 11–13, pc_stall=ifid_flush=1; halt=1 from cycle 14 and held for 20 further cycles.
- mem_busy during drain: mem_busy=1 in cycle 12 → all four holds asserted that cycle, flush 0; halt first asserts in cycle 15.
- Reset in HALT: rst=1 for one cycle → next cycle state_dbg=0, halt=0, all outputs 0. A new ECALL is then accepted normally.
- Priority: mem_busy=1 together with branch_taken_ex=1 and load-use → holds only, no flush. Branch handled once mem_busy drops.
